// File: rtl/xmuxn_delay_pkg.sv
// -----------------------------------------------------------------------------
// xmuxn_delay_pkg
// Shared types for the delayed N-way registered mux and the units that reuse
// its delay counter.
//   state_t : control state encoding (IDLE / WAIT / ACTIVE)
//   sel_width : select width for a given lane count (at least one bit)
// -----------------------------------------------------------------------------
package xmuxn_delay_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_WAIT   = 2'd1,
        ST_ACTIVE = 2'd2
    } state_t;

    function automatic int sel_width(input int n_lanes);
        return (n_lanes <= 2) ? 1 : $clog2(n_lanes);
    endfunction

endpackage

// File: rtl/xdelay_cnt.sv
// -----------------------------------------------------------------------------
// xdelay_cnt
// Loadable down-counter used to hold off a unit for a programmed number of
// cycles. Load has priority over decrement; the count saturates at zero.
// Ports:
//   clk      in   clock
//   rst      in   asynchronous active-high reset (count 0, zero flag 1)
//   load     in   load load_val on this edge
//   load_val in   DELAY_W value to load
//   en       in   decrement enable (ignored while the count is zero)
//   cnt      out  current count
//   zero     out  registered flag, high when cnt is zero
// -----------------------------------------------------------------------------
module xdelay_cnt #(
    parameter int DELAY_W = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               load,
    input  logic [DELAY_W-1:0] load_val,
    input  logic               en,
    output logic [DELAY_W-1:0] cnt,
    output logic               zero
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt  <= '0;
            zero <= 1'b1;
        end else if (load) begin
            cnt  <= load_val;
            zero <= (load_val == '0);
        end else if (en && !zero) begin
            cnt  <= cnt - DELAY_W'(1);
            // Flag follows the value being written, so it stays registered.
            zero <= (cnt == DELAY_W'(1));
        end
    end

endmodule

// File: rtl/xmuxn_delay.sv
// -----------------------------------------------------------------------------
// xmuxn_delay
// Registered N-way data mux with a configuration latched on run_i and a
// programmable start delay, so the output can be aligned with pipelined
// neighbours. While ACTIVE, each edge forwards lane[cfg_sel] to out0_o.
// Ports:
//   clk_i      in   clock
//   rst_i      in   asynchronous active-high reset
//   running_i  in   run in progress; low (without run_i) returns to IDLE
//   run_i      in   one-cycle start pulse; latches sel_i / delay_i
//   done_o     out  high whenever the start delay is not being counted
//   in_i       in   packed lanes, lane k = in_i[k*DATA_W +: DATA_W]
//   sel_i      in   lane select, sampled on run_i
//   delay_i    in   start delay in cycles, sampled on run_i
//   out0_o     out  registered selected lane
//   valid_o    out  out0_o was updated on the last edge
// -----------------------------------------------------------------------------
module xmuxn_delay
    import xmuxn_delay_pkg::*;
#(
    parameter int DATA_W  = 32,
    parameter int N_IN    = 8,
    parameter int DELAY_W = 8,
    localparam int SEL_W  = sel_width(N_IN)
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   running_i,
    input  logic                   run_i,
    output logic                   done_o,
    input  logic [N_IN*DATA_W-1:0] in_i,
    input  logic [SEL_W-1:0]       sel_i,
    input  logic [DELAY_W-1:0]     delay_i,
    output logic [DATA_W-1:0]      out0_o,
    output logic                   valid_o
);

    state_t              state;
    state_t              state_nxt;
    logic [SEL_W-1:0]    cfg_sel;
    logic [DELAY_W-1:0]  cnt;
    logic                cnt_zero;
    logic signed [DATA_W-1:0] lane_p0;

    // The delay itself needs no separate shadow copy: the counter loads it on
    // the same run_i edge and nothing reads the programmed value afterwards.
    xdelay_cnt #(
        .DELAY_W (DELAY_W)
    ) u_cnt (
        .clk      (clk_i),
        .rst      (rst_i),
        .load     (run_i),
        .load_val (delay_i),
        .en       ((state == ST_WAIT) && running_i),
        .cnt      (cnt),
        .zero     (cnt_zero)
    );

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state   <= ST_IDLE;
            cfg_sel <= '0;
        end else begin
            state <= state_nxt;
            if (run_i) begin
                cfg_sel <= sel_i;
            end
        end
    end

    // run_i outranks running_i so a run can be started in the same cycle the
    // accelerator raises running.
    always_comb begin
        state_nxt = state;
        if (run_i) begin
            state_nxt = (delay_i == '0) ? ST_ACTIVE : ST_WAIT;
        end else if (!running_i) begin
            state_nxt = ST_IDLE;
        end else begin
            case (state)
                // Leave on the edge that takes the count from 1 to 0.
                ST_WAIT: if (cnt == DELAY_W'(1) || cnt_zero) state_nxt = ST_ACTIVE;
                default: state_nxt = state;
            endcase
        end
    end

    // Select lane; out-of-range selects (non power-of-two N_IN) forward zero.
    always_comb begin
        lane_p0 = '0;
        if (int'(cfg_sel) < N_IN) begin
            lane_p0 = in_i[int'(cfg_sel)*DATA_W +: DATA_W];
        end
    end

    // ---- stage p0 -> output register ----
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            out0_o  <= '0;
            valid_o <= 1'b0;
        end else if (state == ST_ACTIVE) begin
            out0_o  <= lane_p0;
            valid_o <= 1'b1;
        end else begin
            valid_o <= 1'b0;
        end
    end

    assign done_o = (state != ST_WAIT);

endmodule
